// File: rtl/sbox_share_arbiter.sv
// sbox_share_arbiter: two requesters share a bank of LANES forward AES S-box lanes.
//   - the round datapath asks for SubBytes on a 128-bit state (ST jobs)
//   - the key schedule asks for SubWord on a 32-bit word (KW jobs)
// Requests are arbitrated round-robin with a valid/ready handshake. An accepted
// job is copied into a shared work register, and LANES bytes are substituted in
// place on every beat. A one-cycle done pulse marks the end of each job.
// Optional feature macro: SBOX_SHARE_ARBITER_INVERSE_EN adds the st_inv input
// and an inverse S-box per lane, so ST jobs can use InvSubBytes.
module sbox_share_arbiter #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         st_valid,
   output logic         st_ready,
   input  logic [127:0] st_data,
`ifdef SBOX_SHARE_ARBITER_INVERSE_EN
   input  logic         st_inv,
`endif
   output logic         st_done,
   output logic [127:0] st_result,
   input  logic         kw_valid,
   output logic         kw_ready,
   input  logic [31:0]  kw_data,
   output logic         kw_done,
   output logic [31:0]  kw_result,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN_ST = 2'd1,
      RUN_KW = 2'd2
   } state_e;

   typedef enum logic {
      RR_ST = 1'b0,
      RR_KW = 1'b1
   } rr_e;

   localparam int         ST_BEATS = 16 / LANES;
   localparam int         KW_BEATS = 4 / LANES;
   localparam logic [3:0] ST_LAST  = 4'(ST_BEATS - 1);
   localparam logic [3:0] KW_LAST  = 4'(KW_BEATS - 1);
   localparam logic [3:0] LANES_W  = 4'(LANES);

   // Only 1, 2 or 4 lanes divide both job sizes evenly.
   if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_lanes_check
      $error("sbox_share_arbiter: LANES must be 1, 2 or 4");
   end

   // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] prod;
      logic [7:0] x;
      prod = 8'h00;
      x    = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            prod = prod ^ x;
         end
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return prod;
   endfunction

   // The multiplicative inverse is a^254. It is built from the squares
   // a^2, a^4, ... a^128, and 0 maps to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // Forward S-box: field inverse followed by the AES affine map.
   function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

`ifdef SBOX_SHARE_ARBITER_INVERSE_EN
   // Inverse S-box: inverse affine map followed by the field inverse.
   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
   endfunction
`endif

   state_e               state_q, state_d;
   rr_e                  rr_last_q, rr_last_d;
   logic [127:0]         work_q, work_d;
   logic [127:0]         work_subst;
   logic [3:0]           count_q, count_d;
   logic                 st_done_q, st_done_d;
   logic                 kw_done_q, kw_done_d;
   logic                 grant_st, grant_kw;
   logic [8*LANES-1:0]   lane_in;
   logic [8*LANES-1:0]   lane_out;

`ifdef SBOX_SHARE_ARBITER_INVERSE_EN
   logic                 st_inv_q, st_inv_d;
   logic                 use_inv;
   assign use_inv = (state_q == RUN_ST) && st_inv_q;
`endif

   // Round-robin grant: a lone requester wins, and a tie goes to whoever was not served last.
   always_comb begin
      grant_st = 1'b0;
      grant_kw = 1'b0;
      if (st_valid && kw_valid) begin
         grant_st = (rr_last_q == RR_KW);
         grant_kw = (rr_last_q == RR_ST);
      end else begin
         grant_st = st_valid;
         grant_kw = kw_valid;
      end
   end

   assign st_ready = rst_n && (state_q == IDLE) && grant_st;
   assign kw_ready = rst_n && (state_q == IDLE) && grant_kw;

   // Gather the bytes the lanes work on this beat, starting at byte count*LANES.
   always_comb begin : p_lane_gather
      logic [3:0] pos;
      pos     = 4'd0;
      lane_in = '0;
      for (int i = 0; i < LANES; i++) begin
         pos                = count_q * LANES_W + 4'(i);
         lane_in[8*i +: 8]  = work_q[{pos, 3'b000} +: 8];
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
`ifdef SBOX_SHARE_ARBITER_INVERSE_EN
      assign lane_out[8*g +: 8] = use_inv ? inv_sbox(lane_in[8*g +: 8])
                                          : fwd_sbox(lane_in[8*g +: 8]);
`else
      assign lane_out[8*g +: 8] = fwd_sbox(lane_in[8*g +: 8]);
`endif
   end

   // Write the substituted lane bytes back into their positions in the work register.
   always_comb begin : p_lane_merge
      logic [3:0] pos;
      pos        = 4'd0;
      work_subst = work_q;
      for (int i = 0; i < LANES; i++) begin
         pos                                = count_q * LANES_W + 4'(i);
         work_subst[{pos, 3'b000} +: 8]     = lane_out[8*i +: 8];
      end
   end

   // Next-state logic: accept a job from IDLE, then run beats until the last one and pulse done.
   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      work_d    = work_q;
      count_d   = count_q;
      st_done_d = 1'b0;
      kw_done_d = 1'b0;
`ifdef SBOX_SHARE_ARBITER_INVERSE_EN
      st_inv_d  = st_inv_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (st_valid && st_ready) begin
               work_d    = st_data;
               count_d   = 4'd0;
               rr_last_d = RR_ST;
               state_d   = RUN_ST;
`ifdef SBOX_SHARE_ARBITER_INVERSE_EN
               st_inv_d  = st_inv;
`endif
            end else if (kw_valid && kw_ready) begin
               work_d    = {96'b0, kw_data};
               count_d   = 4'd0;
               rr_last_d = RR_KW;
               state_d   = RUN_KW;
            end
         end
         RUN_ST: begin
            work_d  = work_subst;
            count_d = count_q + 4'd1;
            if (count_q == ST_LAST) begin
               state_d   = IDLE;
               st_done_d = 1'b1;
            end
         end
         RUN_KW: begin
            work_d  = work_subst;
            count_d = count_q + 4'd1;
            if (count_q == KW_LAST) begin
               state_d   = IDLE;
               kw_done_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. Reset discards any job in flight, and the key schedule wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_last_q <= RR_ST;
         work_q    <= '0;
         count_q   <= 4'd0;
         st_done_q <= 1'b0;
         kw_done_q <= 1'b0;
`ifdef SBOX_SHARE_ARBITER_INVERSE_EN
         st_inv_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         work_q    <= work_d;
         count_q   <= count_d;
         st_done_q <= st_done_d;
         kw_done_q <= kw_done_d;
`ifdef SBOX_SHARE_ARBITER_INVERSE_EN
         st_inv_q  <= st_inv_d;
`endif
      end
   end

   assign busy      = (state_q != IDLE);
   assign st_done   = st_done_q;
   assign kw_done   = kw_done_q;
   assign st_result = work_q;
   assign kw_result = work_q[31:0];

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Testbench for sbox_share_arbiter.
// A cycle-level reference model tracks grants, busy time, done timing and
// results. The model uses S-box tables that are built from the field definition
// by brute-force inversion.
module tb_sbox_share_arbiter;

   localparam int LANES  = 4;
   localparam int ST_LAT = 16 / LANES + 1;
   localparam int KW_LAT = 4 / LANES + 1;
`ifdef SBOX_SHARE_ARBITER_INVERSE_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   localparam logic [127:0] ST_VEC  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] ST_GOLD = 128'h638293c31bfc33f5c4eeacea4bc12816;
   localparam logic [31:0]  KW_VEC  = 32'hcf4f3c09;
   localparam logic [31:0]  KW_GOLD = 32'h8a84eb01;

   logic         clk;
   logic         rst_n;
   logic         st_valid, st_ready, st_done, st_inv;
   logic [127:0] st_data, st_result;
   logic         kw_valid, kw_ready, kw_done;
   logic [31:0]  kw_data, kw_result;
   logic         busy;

   logic [7:0]   fwd_tab [256];
   logic [7:0]   inv_tab [256];

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           st_done_at = -1;
   int           kw_done_at = -1;
   int           busy_lo = 0;
   int           busy_hi = -1;
   logic [127:0] st_exp = '0;
   logic [31:0]  kw_exp = '0;
   logic [127:0] st_seen = '1;
   logic [31:0]  kw_seen = '1;
   bit           last_kw = 1'b0;
   bit           acc_st = 1'b0;
   bit           acc_kw = 1'b0;

   sbox_share_arbiter #(.LANES(LANES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_data   (st_data),
`ifdef SBOX_SHARE_ARBITER_INVERSE_EN
      .st_inv    (st_inv),
`endif
      .st_done   (st_done),
      .st_result (st_result),
      .kw_valid  (kw_valid),
      .kw_ready  (kw_ready),
      .kw_data   (kw_data),
      .kw_done   (kw_done),
      .kw_result (kw_result),
      .busy      (busy)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so that a stuck run still ends with a message.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [127:0] refSub(input logic [127:0] d, input bit inv);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) begin
         r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
      end
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Compare one cycle of DUT outputs with the model, then record any accept the rules imply.
   task automatic sampleCycle();
      logic         idle, exp_st_rdy, exp_kw_rdy;
      logic [127:0] tmp;
      acc_st = 1'b0;
      acc_kw = 1'b0;
      if (!rst_n) begin
         st_done_at = -1;
         kw_done_at = -1;
         busy_hi    = -1;
         last_kw    = 1'b0;
      end
      idle       = !(cyc >= busy_lo && cyc <= busy_hi);
      exp_st_rdy = rst_n && idle && st_valid && (!kw_valid || last_kw);
      exp_kw_rdy = rst_n && idle && kw_valid && (!st_valid || !last_kw);
      checkOutput("st_ready", st_ready, exp_st_rdy);
      checkOutput("kw_ready", kw_ready, exp_kw_rdy);
      checkOutput("busy", busy, !idle);
      checkOutput("st_done", st_done, cyc == st_done_at);
      checkOutput("kw_done", kw_done, cyc == kw_done_at);
      if (cyc == st_done_at) checkOutput("st_result", st_result, st_exp);
      if (cyc == kw_done_at) checkOutput("kw_result", kw_result, kw_exp);
      if (!rst_n) begin
         checkOutput("rst_st_result", st_result, '0);
         checkOutput("rst_kw_result", kw_result, '0);
      end
      if (st_done === 1'b1) st_seen = st_result;
      if (kw_done === 1'b1) kw_seen = kw_result;
      if (exp_st_rdy) begin
         st_exp     = refSub(st_data, INV_EN && st_inv);
         st_done_at = cyc + ST_LAT;
         busy_lo    = cyc + 1;
         busy_hi    = cyc + ST_LAT - 1;
         last_kw    = 1'b0;
         acc_st     = 1'b1;
      end else if (exp_kw_rdy) begin
         tmp        = refSub({96'b0, kw_data}, 1'b0);
         kw_exp     = tmp[31:0];
         kw_done_at = cyc + KW_LAT;
         busy_lo    = cyc + 1;
         busy_hi    = cyc + KW_LAT - 1;
         last_kw    = 1'b1;
         acc_kw     = 1'b1;
      end
      cyc++;
   endtask

   task automatic applyStimulus(input logic rst_v, input logic stv, input logic [127:0] std,
                                input logic kwv, input logic [31:0] kwd, input logic inv);
      @(negedge clk);
      rst_n    = rst_v;
      st_valid = stv;
      st_data  = std;
      kw_valid = kwv;
      kw_data  = kwd;
      st_inv   = inv;
      #1;
      sampleCycle();
   endtask

   initial begin
      int n;
      logic [7:0] c;
      rst_n    = 1'b0;
      st_valid = 1'b0;
      kw_valid = 1'b0;
      st_data  = '0;
      kw_data  = '0;
      st_inv   = 1'b0;
      c        = 8'h63;

      // Reference tables: brute-force inverse, then the bitwise affine map.
      for (int x = 0; x < 256; x++) begin
         logic [7:0] iv;
         logic [7:0] s;
         iv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
         end
         for (int i = 0; i < 8; i++) begin
            s[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ c[i];
         end
         fwd_tab[x] = s;
         inv_tab[s] = 8'(x);
      end

      $display("[TB] reset with both requests pending");
      repeat (3) applyStimulus(1'b0, 1'b1, rnd128(), 1'b1, $urandom, 1'b0);
      repeat (2) applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);

      $display("[TB] directed state job");
      st_seen = '1;
      n = 0;
      do begin
         applyStimulus(1'b1, 1'b1, ST_VEC, 1'b0, '0, 1'b0);
         n++;
      end while (!acc_st && n < 8);
      repeat (ST_LAT + 1) applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      checkOutput("st_vector", st_seen, ST_GOLD);

      $display("[TB] directed key-word job");
      kw_seen = '1;
      n = 0;
      do begin
         applyStimulus(1'b1, 1'b0, '0, 1'b1, KW_VEC, 1'b0);
         n++;
      end while (!acc_kw && n < 8);
      repeat (KW_LAT + 1) applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      checkOutput("kw_vector", kw_seen, {96'b0, KW_GOLD});

      $display("[TB] both requesters held from reset");
      repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      repeat (3 * (ST_LAT + KW_LAT)) applyStimulus(1'b1, 1'b1, rnd128(), 1'b1, $urandom, 1'b0);
      repeat (ST_LAT + 1) applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);

      $display("[TB] back-to-back state jobs");
      repeat (3 * ST_LAT + 1) applyStimulus(1'b1, 1'b1, rnd128(), 1'b0, '0, 1'b0);
      repeat (ST_LAT + 1) applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);

      $display("[TB] random traffic");
      repeat (300) applyStimulus(1'b1, 1'($urandom_range(0, 1)), rnd128(),
                                 1'($urandom_range(0, 1)), $urandom,
                                 1'($urandom_range(0, 1)) & INV_EN);
      repeat (ST_LAT + 1) applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);

      $display("[TB] reset during a state job");
      n = 0;
      do begin
         applyStimulus(1'b1, 1'b1, rnd128(), 1'b0, '0, 1'b0);
         n++;
      end while (!acc_st && n < 8);
      repeat (2) applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      repeat (ST_LAT) applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      kw_seen = '1;
      n = 0;
      do begin
         applyStimulus(1'b1, 1'b0, '0, 1'b1, KW_VEC, 1'b0);
         n++;
      end while (!acc_kw && n < 8);
      repeat (KW_LAT + 1) applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      checkOutput("kw_after_reset", kw_seen, {96'b0, KW_GOLD});

`ifdef SBOX_SHARE_ARBITER_INVERSE_EN
      $display("[TB] inverse state job");
      st_seen = '1;
      n = 0;
      do begin
         applyStimulus(1'b1, 1'b1, {16{8'h63}}, 1'b0, '0, 1'b1);
         n++;
      end while (!acc_st && n < 8);
      repeat (ST_LAT + 1) applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      checkOutput("inv_vector", st_seen, '0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
